// File: rtl/mem_stage.sv
// MIPS memory stage: word-addressed data memory with fixed wait states,
// stall generation toward upstream stages, and the MEM/WB output register.
module mem_stage #(
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_CYCLES = 2,
    parameter int BASE_ADDR   = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        WB_EN_in,
    input  logic        MEM_R_EN_in,
    input  logic        MEM_W_EN_in,
    input  logic [31:0] PC_in,
    input  logic [31:0] ALU_result_in,
    input  logic [31:0] ST_val_in,
    input  logic [4:0]  Dest_in,
    output logic        freeze,
    output logic        WB_EN,
    output logic        MEM_R_EN,
    output logic [31:0] PC,
    output logic [31:0] ALU_result,
    output logic [31:0] MEM_result,
    output logic [4:0]  Dest,
    output logic        addr_err
);
    localparam int          IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [31:0] BASE      = 32'(BASE_ADDR);
    localparam logic [29:0] BASE_WORD = 30'(BASE_ADDR >> 2);
    localparam logic [29:0] DEPTH_LIM = 30'(DEPTH_WORDS);
    localparam logic [3:0]  CNT_INIT  = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
    localparam logic        HAS_WAIT  = (WAIT_CYCLES > 0);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] WAIT = 1'b1;

    logic [31:0]      mem [DEPTH_WORDS];
    logic [0:0]       state;
    logic [3:0]       cnt;
    logic             mem_op;
    logic [29:0]      word_off;
    logic [IDX_W-1:0] idx;
    logic             fault;
    logic             start_wait;
    logic             complete;
    logic             pass;
    logic [31:0]      rd_word;

    // Base is word aligned, so the word offset is the byte offset >> 2;
    // a below-base address wraps to a huge offset and also trips the range test.
    function automatic logic addr_fault(input logic [31:0] addr, input logic [29:0] off);
        return (addr[1:0] != 2'b00) || (addr < BASE) || (off >= DEPTH_LIM);
    endfunction

    always_comb begin
        mem_op     = MEM_R_EN_in | MEM_W_EN_in;
        word_off   = ALU_result_in[31:2] - BASE_WORD;
        idx        = word_off[IDX_W-1:0];
        fault      = addr_fault(ALU_result_in, word_off);
        start_wait = (state == IDLE) && mem_op && HAS_WAIT;
        complete   = ((state == IDLE) && mem_op && !HAS_WAIT) ||
                     ((state == WAIT) && (cnt == 4'd0));
        pass       = (state == IDLE) && !mem_op;
        freeze     = !rst && (start_wait || ((state == WAIT) && (cnt != 4'd0)));
        rd_word    = mem[idx];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_wait) begin
                        state <= WAIT;
                        cnt   <= CNT_INIT;
                    end
                end
                default: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

    // Array is deliberately not cleared by reset; an aborted access never commits.
    always_ff @(posedge clk) begin
        if (!rst && complete && MEM_W_EN_in && !fault) begin
            mem[idx] <= ST_val_in;
        end
    end

    // MEM/WB boundary: stalled non-completion cycles emit a bubble.
    always_ff @(posedge clk) begin
        if (rst || !(complete || pass)) begin
            WB_EN      <= 1'b0;
            MEM_R_EN   <= 1'b0;
            PC         <= 32'd0;
            ALU_result <= 32'd0;
            MEM_result <= 32'd0;
            Dest       <= 5'd0;
            addr_err   <= 1'b0;
        end else begin
            WB_EN      <= WB_EN_in;
            MEM_R_EN   <= MEM_R_EN_in;
            PC         <= PC_in;
            ALU_result <= ALU_result_in;
            MEM_result <= (complete && MEM_R_EN_in && !fault) ? rd_word : 32'd0;
            Dest       <= Dest_in;
            addr_err   <= complete && fault;
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized
// traffic compared against an array-based reference model.
module tb_mem_stage;
    localparam int DEPTH = 64;
    localparam int WAITC = 2;
    localparam int BASE  = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        WB_EN_in, MEM_R_EN_in, MEM_W_EN_in;
    logic [31:0] PC_in, ALU_result_in, ST_val_in;
    logic [4:0]  Dest_in;
    logic        freeze, WB_EN, MEM_R_EN, addr_err;
    logic [31:0] PC, ALU_result, MEM_result;
    logic [4:0]  Dest;

    int checks = 0;
    int failures = 0;

    logic [31:0] model_mem [DEPTH];

    int          obs_frz_cnt;
    logic        obs_frz_last;
    logic        obs_bubble_ok;
    logic        o_wb, o_r, o_err;
    logic [31:0] o_pc, o_alu, o_mem;
    logic [4:0]  o_dest;

    logic        e_wb, e_r, e_err;
    logic [31:0] e_pc, e_alu, e_mem;
    logic [4:0]  e_dest;

    mem_stage #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst),
        .WB_EN_in(WB_EN_in), .MEM_R_EN_in(MEM_R_EN_in), .MEM_W_EN_in(MEM_W_EN_in),
        .PC_in(PC_in), .ALU_result_in(ALU_result_in), .ST_val_in(ST_val_in),
        .Dest_in(Dest_in), .freeze(freeze), .WB_EN(WB_EN), .MEM_R_EN(MEM_R_EN),
        .PC(PC), .ALU_result(ALU_result), .MEM_result(MEM_result), .Dest(Dest),
        .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic bit model_fault(input logic [31:0] addr);
        longint a;
        a = longint'(addr);
        return (a % 4 != 0) || (a < BASE) || ((a - BASE) / 4 >= DEPTH);
    endfunction

    // Reference model: what the MEM/WB register should hold after this op.
    task automatic model_op(input logic wb, r, w, input logic [31:0] pc, addr, st,
                            input logic [4:0] dest);
        bit f;
        int ix;
        f = (r | w) && model_fault(addr);
        ix = f ? 0 : int'((longint'(addr) - BASE) / 4);
        e_wb = wb; e_r = r; e_pc = pc; e_alu = addr; e_dest = dest;
        e_err = f;
        e_mem = (r && !f) ? model_mem[ix] : 32'd0;
        if (w && !f) model_mem[ix] = st;
    endtask

    task automatic drive(input logic wb, r, w, input logic [31:0] pc, addr, st,
                         input logic [4:0] dest);
        WB_EN_in = wb; MEM_R_EN_in = r; MEM_W_EN_in = w;
        PC_in = pc; ALU_result_in = addr; ST_val_in = st; Dest_in = dest;
    endtask

    // Holds one instruction on the inputs for its full duration (called at posedge+1).
    task automatic run_op(input logic wb, r, w, input logic [31:0] pc, addr, st,
                          input logic [4:0] dest);
        int n;
        n = (r | w) ? WAITC + 1 : 1;
        drive(wb, r, w, pc, addr, st, dest);
        obs_frz_cnt = 0;
        obs_bubble_ok = 1'b1;
        for (int i = 0; i < n; i++) begin
            #3;
            if (i < n - 1) begin
                if (freeze === 1'b1) obs_frz_cnt++;
            end else begin
                obs_frz_last = freeze;
            end
            @(posedge clk);
            #1;
            if (i < n - 1) begin
                if ({WB_EN, MEM_R_EN, PC, ALU_result, MEM_result, Dest, addr_err} !== '0)
                    obs_bubble_ok = 1'b0;
            end else begin
                o_wb = WB_EN; o_r = MEM_R_EN; o_pc = PC; o_alu = ALU_result;
                o_mem = MEM_result; o_dest = Dest; o_err = addr_err;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 32'h40, 32'd1028, 32'h1, 5'd3);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (freeze !== 1'b0) begin
                failures++;
                $display("FAIL reset_freeze: got %b expected 0", freeze);
            end
        end
        @(posedge clk);
        #1;
        checks++;
        if ({WB_EN, MEM_R_EN, PC, ALU_result, MEM_result, Dest, addr_err} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got wb=%b r=%b pc=%h alu=%h mem=%h dest=%0d err=%b expected all 0",
                     WB_EN, MEM_R_EN, PC, ALU_result, MEM_result, Dest, addr_err);
        end
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0);
        #3;
        checks++;
        if (freeze !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle_freeze: got %b expected 0", freeze);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_fill;
        int bad;
        logic [31:0] v;
        bad = 0;
        for (int i = 0; i < DEPTH; i++) begin
            v = $urandom;
            model_op(1'b0, 1'b0, 1'b1, 32'h100 + 32'(i), 32'(BASE + 4 * i), v, 5'd0);
            run_op(1'b0, 1'b0, 1'b1, 32'h100 + 32'(i), 32'(BASE + 4 * i), v, 5'd0);
            if (obs_frz_cnt != WAITC || obs_frz_last !== 1'b0 || !obs_bubble_ok || o_err !== 1'b0)
                bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL fill_timing: got %0d bad stores expected 0", bad);
        end
    endtask

    task automatic test_store_load;
        model_op(1'b0, 1'b0, 1'b1, 32'h200, 32'd1028, 32'hDEADBEEF, 5'd0);
        run_op(1'b0, 1'b0, 1'b1, 32'h200, 32'd1028, 32'hDEADBEEF, 5'd0);
        checks++;
        if (obs_frz_cnt != 2 || obs_frz_last !== 1'b0 || !obs_bubble_ok) begin
            failures++;
            $display("FAIL store_timing: got freeze_cycles=%0d last=%b bubble_ok=%b expected 2/0/1",
                     obs_frz_cnt, obs_frz_last, obs_bubble_ok);
        end
        model_op(1'b1, 1'b1, 1'b0, 32'h204, 32'd1028, 32'd0, 5'd7);
        run_op(1'b1, 1'b1, 1'b0, 32'h204, 32'd1028, 32'd0, 5'd7);
        checks++;
        if (obs_frz_cnt != 2 || obs_frz_last !== 1'b0 || !obs_bubble_ok) begin
            failures++;
            $display("FAIL load_timing: got freeze_cycles=%0d last=%b bubble_ok=%b expected 2/0/1",
                     obs_frz_cnt, obs_frz_last, obs_bubble_ok);
        end
        checks++;
        if (o_mem !== 32'hDEADBEEF || o_wb !== 1'b1 || o_r !== 1'b1 || o_dest !== 5'd7 ||
            o_pc !== 32'h204 || o_err !== 1'b0) begin
            failures++;
            $display("FAIL load_result: got mem=%h wb=%b r=%b dest=%0d pc=%h err=%b expected deadbeef/1/1/7/204/0",
                     o_mem, o_wb, o_r, o_dest, o_pc, o_err);
        end
    endtask

    task automatic test_alu_ops;
        for (int i = 5; i <= 7; i++) begin
            run_op(1'b1, 1'b0, 1'b0, 32'h300 + 32'(i), 32'(i), 32'hFFFF, 5'(i));
            checks++;
            if (o_alu !== 32'(i) || o_mem !== 32'd0 || obs_frz_last !== 1'b0 || o_wb !== 1'b1 ||
                o_dest !== 5'(i)) begin
                failures++;
                $display("FAIL alu_op_%0d: got alu=%h mem=%h freeze=%b wb=%b dest=%0d expected %h/0/0/1/%0d",
                         i, o_alu, o_mem, obs_frz_last, o_wb, o_dest, i, i);
            end
        end
    endtask

    task automatic test_misaligned;
        model_op(1'b1, 1'b1, 1'b0, 32'h400, 32'd1030, 32'd0, 5'd9);
        run_op(1'b1, 1'b1, 1'b0, 32'h400, 32'd1030, 32'd0, 5'd9);
        checks++;
        if (obs_frz_cnt != 2 || o_mem !== 32'd0 || o_err !== 1'b1 || o_wb !== 1'b1) begin
            failures++;
            $display("FAIL misaligned_load: got freeze_cycles=%0d mem=%h err=%b wb=%b expected 2/0/1/1",
                     obs_frz_cnt, o_mem, o_err, o_wb);
        end
        run_op(1'b0, 1'b0, 1'b0, 32'h404, 32'd1, 32'd0, 5'd0);
        checks++;
        if (o_err !== 1'b0) begin
            failures++;
            $display("FAIL err_pulse_width: got %b expected 0", o_err);
        end
        model_op(1'b0, 1'b0, 1'b1, 32'h408, 32'd1030, 32'h11111111, 5'd0);
        run_op(1'b0, 1'b0, 1'b1, 32'h408, 32'd1030, 32'h11111111, 5'd0);
        checks++;
        if (o_err !== 1'b1) begin
            failures++;
            $display("FAIL misaligned_store_err: got %b expected 1", o_err);
        end
        for (int a = 1028; a <= 1032; a += 4) begin
            model_op(1'b1, 1'b1, 1'b0, 32'h40C, 32'(a), 32'd0, 5'd1);
            run_op(1'b1, 1'b1, 1'b0, 32'h40C, 32'(a), 32'd0, 5'd1);
            checks++;
            if (o_mem !== e_mem) begin
                failures++;
                $display("FAIL misaligned_neighbour_%0d: got %h expected %h", a, o_mem, e_mem);
            end
        end
    endtask

    task automatic test_out_of_range;
        model_op(1'b0, 1'b0, 1'b1, 32'h500, 32'd1024, 32'hCAFE0001, 5'd0);
        run_op(1'b0, 1'b0, 1'b1, 32'h500, 32'd1024, 32'hCAFE0001, 5'd0);
        model_op(1'b0, 1'b0, 1'b1, 32'h504, 32'(BASE + 4 * DEPTH), 32'h12345678, 5'd0);
        run_op(1'b0, 1'b0, 1'b1, 32'h504, 32'(BASE + 4 * DEPTH), 32'h12345678, 5'd0);
        checks++;
        if (o_err !== 1'b1 || obs_frz_cnt != 2) begin
            failures++;
            $display("FAIL oor_store: got err=%b freeze_cycles=%0d expected 1/2", o_err, obs_frz_cnt);
        end
        model_op(1'b1, 1'b1, 1'b0, 32'h508, 32'd1024, 32'd0, 5'd2);
        run_op(1'b1, 1'b1, 1'b0, 32'h508, 32'd1024, 32'd0, 5'd2);
        checks++;
        if (o_mem !== 32'hCAFE0001 || o_err !== 1'b0) begin
            failures++;
            $display("FAIL no_alias: got mem=%h err=%b expected cafe0001/0", o_mem, o_err);
        end
        model_op(1'b1, 1'b1, 1'b0, 32'h50C, 32'd1020, 32'd0, 5'd2);
        run_op(1'b1, 1'b1, 1'b0, 32'h50C, 32'd1020, 32'd0, 5'd2);
        checks++;
        if (o_err !== 1'b1 || o_mem !== 32'd0) begin
            failures++;
            $display("FAIL below_base: got err=%b mem=%h expected 1/0", o_err, o_mem);
        end
    endtask

    task automatic test_reset_mid_wait;
        model_op(1'b0, 1'b0, 1'b1, 32'h600, 32'd1032, 32'hAA, 5'd0);
        run_op(1'b0, 1'b0, 1'b1, 32'h600, 32'd1032, 32'hAA, 5'd0);
        drive(1'b0, 1'b0, 1'b1, 32'h604, 32'd1032, 32'h55, 5'd0);
        @(posedge clk);
        #1;
        checks++;
        if (freeze !== 1'b1) begin
            failures++;
            $display("FAIL wait_freeze: got %b expected 1", freeze);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (freeze !== 1'b0) begin
            failures++;
            $display("FAIL rst_freeze_drop: got %b expected 0", freeze);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0);
        #1;
        checks++;
        if (freeze !== 1'b0 || {WB_EN, PC, ALU_result, addr_err} !== '0) begin
            failures++;
            $display("FAIL rst_mid_wait_state: got freeze=%b pc=%h alu=%h expected 0/0/0", freeze, PC, ALU_result);
        end
        @(posedge clk);
        #1;
        model_op(1'b1, 1'b1, 1'b0, 32'h608, 32'd1032, 32'd0, 5'd4);
        run_op(1'b1, 1'b1, 1'b0, 32'h608, 32'd1032, 32'd0, 5'd4);
        checks++;
        if (o_mem !== 32'hAA || obs_frz_cnt != 2) begin
            failures++;
            $display("FAIL aborted_store: got mem=%h freeze_cycles=%0d expected 000000aa/2", o_mem, obs_frz_cnt);
        end
    endtask

    task automatic test_random;
        logic wb, r, w;
        logic [31:0] pc, addr, st;
        logic [4:0] dest;
        int kind, bad_timing, bad_data;
        bad_timing = 0;
        bad_data = 0;
        for (int n = 0; n < 80; n++) begin
            kind = int'($urandom_range(0, 3));
            r = (kind == 1 || kind == 3);
            w = (kind == 2 || kind == 3);
            wb = 1'($urandom);
            pc = $urandom;
            st = $urandom;
            dest = 5'($urandom);
            case ($urandom_range(0, 9))
                0: addr = 32'(BASE + 4 * int'($urandom_range(0, DEPTH - 1)) + int'($urandom_range(1, 3)));
                1: addr = 32'(BASE + 4 * DEPTH + 4 * int'($urandom_range(0, 8)));
                2: addr = 32'(BASE - 4 * int'($urandom_range(1, 8)));
                default: addr = 32'(BASE + 4 * int'($urandom_range(0, DEPTH - 1)));
            endcase
            model_op(wb, r, w, pc, addr, st, dest);
            run_op(wb, r, w, pc, addr, st, dest);
            if (obs_frz_cnt != ((r | w) ? WAITC : 0) || obs_frz_last !== 1'b0 || !obs_bubble_ok)
                bad_timing++;
            checks++;
            if (o_wb !== e_wb || o_r !== e_r || o_pc !== e_pc || o_alu !== e_alu ||
                o_mem !== e_mem || o_dest !== e_dest || o_err !== e_err) begin
                failures++;
                bad_data++;
                if (bad_data <= 5)
                    $display("FAIL random_op_%0d: got wb=%b r=%b pc=%h alu=%h mem=%h dest=%0d err=%b expected wb=%b r=%b pc=%h alu=%h mem=%h dest=%0d err=%b",
                             n, o_wb, o_r, o_pc, o_alu, o_mem, o_dest, o_err,
                             e_wb, e_r, e_pc, e_alu, e_mem, e_dest, e_err);
            end
        end
        checks++;
        if (bad_timing != 0) begin
            failures++;
            $display("FAIL random_timing: got %0d ops with wrong freeze/bubble expected 0", bad_timing);
        end
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0);
        @(posedge clk);
        #1;
        test_reset();
        test_fill();
        test_store_load();
        test_alu_ops();
        test_misaligned();
        test_out_of_range();
        test_reset_mid_wait();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
